ybus_rmw_writer: RTL and testbench

//  Parametrised read-modify-write engine that commits Y-bus admittance updates to the Y row memory.

---
 rtl/ybus_rmw_writer.sv | 250 +++++++++++++++++++++++++
 tb/tb_ybus_rmw_writer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ybus_rmw_writer.sv
// ----------------------------------------------------------------------------
// ybus_rmw_writer
//   Read-modify-write engine that commits Y-bus admittance update pairs
//   (diagonal + non-diagonal element) into the Y row memory. Update pairs are
//   queued in a DEPTH-entry FIFO and retired strictly in order:
//   fetch both rows, merge the new lane payload(s), write the row(s) back.
//
// Ports
//   clock, reset                 rising-edge clock, async active-low reset
//   in_valid / in_ready          update pair handshake (in_ready = FIFO not full)
//   in_diag* / in_nonD*          address, lane one-hot and value of each element
//   op_rdEn, op_rdAddr1/2        one-cycle row fetch strobe and addresses
//   in_YreadData1/2              fetched rows, RD_LAT cycles after op_rdEn
//   op_WEbit, op_writeAddress,
//   op_writeData                 row write port
//   op_writeDone                 pulse: FIFO drained and last write issued
//   op_busy                      engine active or FIFO not empty
//   op_err                       pulse: malformed entry dropped or lane conflict
// ----------------------------------------------------------------------------
module ybus_rmw_writer #(
    parameter int unsigned DW     = 48,
    parameter int unsigned SLOT_W = 64,
    parameter int unsigned LANES  = 4,
    parameter int unsigned AW     = 11,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AW-1:0]             in_diagAddr,
    input  logic [LANES-1:0]          in_diagOH,
    input  logic [DW-1:0]             in_diagVal,
    input  logic [AW-1:0]             in_nonDAddr,
    input  logic [LANES-1:0]          in_nonDiagOH,
    input  logic [DW-1:0]             in_nonDiagVal,
    output logic                      op_rdEn,
    output logic [AW-1:0]             op_rdAddr1,
    output logic [AW-1:0]             op_rdAddr2,
    input  logic [LANES*SLOT_W-1:0]   in_YreadData1,
    input  logic [LANES*SLOT_W-1:0]   in_YreadData2,
    output logic                      op_WEbit,
    output logic [AW-1:0]             op_writeAddress,
    output logic [LANES*SLOT_W-1:0]   op_writeData,
    output logic                      op_writeDone,
    output logic                      op_busy,
    output logic                      op_err
);

    localparam int unsigned RW    = LANES * SLOT_W;
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef struct packed {
        logic [AW-1:0]    d_addr;
        logic [LANES-1:0] d_oh;
        logic [DW-1:0]    d_val;
        logic [AW-1:0]    n_addr;
        logic [LANES-1:0] n_oh;
        logic [DW-1:0]    n_val;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_FETCH, S_WAIT, S_WR_D, S_WR_N, S_DONE
    } state_t;

    // Exactly one bit set.
    function automatic logic is_onehot(input logic [LANES-1:0] v);
        return (v != '0) && ((v & (v - LANES'(1))) == '0);
    endfunction

    // Replace the low DW bits of the selected lane slot; everything else passes.
    function automatic logic [RW-1:0] merge_lane(input logic [RW-1:0]    row,
                                                 input logic [LANES-1:0] oh,
                                                 input logic [DW-1:0]    val);
        logic [RW-1:0] r;
        r = row;
        for (int i = 0; i < int'(LANES); i++) begin
            if (oh[i]) r[i*SLOT_W +: DW] = val;
        end
        return r;
    endfunction

    // ---------------- FIFO ----------------
    entry_t          fifo_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            push_c, pop_c;
    entry_t          entry_in_c;

    assign entry_in_c = '{d_addr: in_diagAddr, d_oh: in_diagOH,    d_val: in_diagVal,
                          n_addr: in_nonDAddr, n_oh: in_nonDiagOH, n_val: in_nonDiagVal};
    assign push_c  = in_valid && in_ready;
    assign count_d = count_q + CW'(push_c) - CW'(pop_c);

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clock) begin
        if (push_c) fifo_q[wr_ptr_q] <= entry_in_c;
    end

    // ---------------- working state ----------------
    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    entry_t          work_q, work_d;
    logic [RW-1:0]   row2_q, row2_d;

    logic            ready_q, ready_d;
    logic            rd_en_q, rd_en_d;
    logic [AW-1:0]   rd_addr1_q, rd_addr1_d, rd_addr2_q, rd_addr2_d;
    logic            we_q, we_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [RW-1:0]   wr_data_q, wr_data_d;
    logic            done_q, done_d, busy_q, busy_d, err_q, err_d;

    logic            same_row_c;
    logic [RW-1:0]   wr_d_row_c, wr_n_row_c;

    assign same_row_c = (work_q.d_addr == work_q.n_addr);
    // Same row: merge non-diagonal first so the diagonal value wins a lane clash.
    assign wr_d_row_c = merge_lane(same_row_c ? merge_lane(in_YreadData1, work_q.n_oh, work_q.n_val)
                                              : in_YreadData1,
                                   work_q.d_oh, work_q.d_val);
    assign wr_n_row_c = merge_lane(row2_q, work_q.n_oh, work_q.n_val);

    // Next state; registered outputs are computed for the state being entered
    // so each strobe is visible during the cycle its state is occupied.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        row2_d     = row2_q;
        pop_c      = 1'b0;
        rd_en_d    = 1'b0;
        rd_addr1_d = rd_addr1_q;
        rd_addr2_d = rd_addr2_q;
        we_d       = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop_c   = 1'b1;
                    work_d  = fifo_q[rd_ptr_q];
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!is_onehot(work_q.d_oh) || !is_onehot(work_q.n_oh)) begin
                    err_d   = 1'b1;
                    state_d = (count_q != '0) ? S_IDLE : S_DONE;
                end else begin
                    state_d    = S_FETCH;
                    rd_en_d    = 1'b1;
                    rd_addr1_d = work_q.d_addr;
                    rd_addr2_d = work_q.n_addr;
                end
            end
            S_FETCH: begin
                cnt_d   = CNT_W'(RD_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    row2_d    = in_YreadData2;
                    state_d   = S_WR_D;
                    we_d      = 1'b1;
                    wr_addr_d = work_q.d_addr;
                    wr_data_d = wr_d_row_c;
                    err_d     = same_row_c && (work_q.d_oh == work_q.n_oh);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WR_D: begin
                if (same_row_c) begin
                    state_d = (count_q != '0) ? S_IDLE : S_DONE;
                end else begin
                    state_d   = S_WR_N;
                    we_d      = 1'b1;
                    wr_addr_d = work_q.n_addr;
                    wr_data_d = wr_n_row_c;
                end
            end
            S_WR_N: state_d = (count_q != '0) ? S_IDLE : S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign done_d  = (state_d == S_DONE);
    assign busy_d  = (state_d != S_IDLE) || (count_d != '0);
    assign ready_d = (count_d != CW'(DEPTH));

    // State, FIFO pointers and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            row2_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr1_q <= '1;
            rd_addr2_q <= '1;
            we_q       <= 1'b0;
            wr_addr_q  <= '1;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            row2_q     <= row2_d;
            if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q    <= count_d;
            ready_q    <= ready_d;
            rd_en_q    <= rd_en_d;
            rd_addr1_q <= rd_addr1_d;
            rd_addr2_q <= rd_addr2_d;
            we_q       <= we_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign in_ready        = ready_q;
    assign op_rdEn         = rd_en_q;
    assign op_rdAddr1      = rd_addr1_q;
    assign op_rdAddr2      = rd_addr2_q;
    assign op_WEbit        = we_q;
    assign op_writeAddress = wr_addr_q;
    assign op_writeData    = wr_data_q;
    assign op_writeDone    = done_q;
    assign op_busy         = busy_q;
    assign op_err          = err_q;

endmodule

// File: tb/tb_ybus_rmw_writer.sv
// ----------------------------------------------------------------------------
// tb_ybus_rmw_writer
//   Directed + randomized bench for ybus_rmw_writer (RD_LAT=3). A row-level
//   reference model predicts every write (address and full row) plus error
//   pulses; a behavioural Y memory with RD_LAT read pipeline feeds the DUT.
// ----------------------------------------------------------------------------
module tb_ybus_rmw_writer;

    localparam int unsigned DW     = 48;
    localparam int unsigned SLOT_W = 64;
    localparam int unsigned LANES  = 4;
    localparam int unsigned AW     = 11;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned RD_LAT = 3;
    localparam int unsigned RW     = LANES * SLOT_W;

    typedef struct packed {
        logic [AW-1:0]    da;
        logic [LANES-1:0] doh;
        logic [DW-1:0]    dv;
        logic [AW-1:0]    na;
        logic [LANES-1:0] noh;
        logic [DW-1:0]    nv;
    } ent_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } wr_t;

    logic            clock = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    ent_t            cur;
    logic            op_rdEn, op_WEbit, op_writeDone, op_busy, op_err;
    logic [AW-1:0]   op_rdAddr1, op_rdAddr2, op_writeAddress;
    logic [RW-1:0]   op_writeData, rdata1, rdata2;
    logic            mem_clear;

    always #5 clock = ~clock;

    ybus_rmw_writer #(
        .DW(DW), .SLOT_W(SLOT_W), .LANES(LANES), .AW(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clock(clock), .reset(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_diagAddr(cur.da), .in_diagOH(cur.doh), .in_diagVal(cur.dv),
        .in_nonDAddr(cur.na), .in_nonDiagOH(cur.noh), .in_nonDiagVal(cur.nv),
        .op_rdEn(op_rdEn), .op_rdAddr1(op_rdAddr1), .op_rdAddr2(op_rdAddr2),
        .in_YreadData1(rdata1), .in_YreadData2(rdata2),
        .op_WEbit(op_WEbit), .op_writeAddress(op_writeAddress), .op_writeData(op_writeData),
        .op_writeDone(op_writeDone), .op_busy(op_busy), .op_err(op_err)
    );

    // Behavioural Y memory: rows read on op_rdEn appear RD_LAT cycles later;
    // zeros are returned for non-strobed cycles so a mistimed capture shows up.
    logic [RW-1:0] mem [1<<AW];
    logic [RW-1:0] p1 [RD_LAT];
    logic [RW-1:0] p2 [RD_LAT];
    always @(posedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '1;
        end else if (op_WEbit) begin
            mem[op_writeAddress] <= op_writeData;
        end
        p1[0] <= op_rdEn ? mem[op_rdAddr1] : '0;
        p2[0] <= op_rdEn ? mem[op_rdAddr2] : '0;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            p1[i] <= p1[i-1];
            p2[i] <= p2[i-1];
        end
    end
    assign rdata1 = p1[RD_LAT-1];
    assign rdata2 = p2[RD_LAT-1];

    // ---------------- reference model & bookkeeping ----------------
    logic [RW-1:0] ref_row [int];
    wr_t           exp_q [$];
    int            n_tests = 0, n_fail = 0;
    int            cyc = 0, n_acc = 0, n_wr = 0, n_done = 0, n_err = 0, exp_err = 0;
    int            last_wr_cyc = 0, done_cyc = 0;
    int            stall_at = -1, acc_base = 0;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [RW-1:0] ref_get(input logic [AW-1:0] a);
        return ref_row.exists(int'(a)) ? ref_row[int'(a)] : {RW{1'b1}};
    endfunction

    function automatic logic [RW-1:0] set_lane(input logic [RW-1:0] row, input logic [LANES-1:0] oh,
                                               input logic [DW-1:0] v);
        logic [RW-1:0] r;
        int idx;
        r   = row;
        idx = $clog2(oh);
        r[idx*SLOT_W +: DW] = v;
        return r;
    endfunction

    // Apply one accepted update pair to the model in arrival order.
    function automatic void model_entry(input ent_t e);
        logic [RW-1:0] r;
        if ($countones(e.doh) != 1 || $countones(e.noh) != 1) begin
            exp_err++;
            return;
        end
        if (e.da == e.na) begin
            r = set_lane(set_lane(ref_get(e.da), e.noh, e.nv), e.doh, e.dv);
            if (e.doh == e.noh) exp_err++;
            ref_row[int'(e.da)] = r;
            exp_q.push_back('{addr: e.da, data: r});
        end else begin
            r = set_lane(ref_get(e.da), e.doh, e.dv);
            ref_row[int'(e.da)] = r;
            exp_q.push_back('{addr: e.da, data: r});
            r = set_lane(ref_get(e.na), e.noh, e.nv);
            ref_row[int'(e.na)] = r;
            exp_q.push_back('{addr: e.na, data: r});
        end
    endfunction

    // One clock: sample #1 after the edge, score writes and pulses.
    task automatic step();
        logic acc;
        wr_t  w;
        acc = in_valid && in_ready;
        @(posedge clock);
        #1;
        cyc++;
        if (acc) begin
            n_acc++;
            model_entry(cur);
        end
        if (op_WEbit) begin
            n_wr++;
            last_wr_cyc = cyc;
            check("write_expected", RW'(exp_q.size() != 0), RW'(1));
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("wr_addr", RW'(op_writeAddress), RW'(w.addr));
                check("wr_data", op_writeData, w.data);
            end
        end
        if (op_writeDone) begin
            n_done++;
            done_cyc = cyc;
        end
        if (op_err) n_err++;
    endtask

    task automatic push_entry(input ent_t e);
        int   n;
        logic got;
        cur      = e;
        in_valid = 1'b1;
        n        = 0;
        got      = 1'b0;
        while (!got && n < 200) begin
            if (!in_ready && stall_at < 0) stall_at = n_acc - acc_base;
            got = in_ready;
            step();
            n++;
        end
        in_valid = 1'b0;
        check("push_accepted", RW'(got), RW'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((op_busy || exp_q.size() != 0) && n < 3000);
        check("idle_timeout", RW'(n < 3000), RW'(1));
        step();
    endtask

    function automatic ent_t mk(input logic [AW-1:0] da, input logic [LANES-1:0] doh, input logic [DW-1:0] dv,
                                input logic [AW-1:0] na, input logic [LANES-1:0] noh, input logic [DW-1:0] nv);
        return '{da: da, doh: doh, dv: dv, na: na, noh: noh, nv: nv};
    endfunction

    initial begin
        int w0, d0, e0, x0;
        logic [RW-1:0] row;
        ent_t e;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        cur       = '0;
        mem_clear = 1'b1;

        // Reset values
        repeat (3) step();
        mem_clear = 1'b0;
        check("rst_in_ready",  RW'(in_ready), RW'(0));
        check("rst_rdEn",      RW'(op_rdEn), RW'(0));
        check("rst_WEbit",     RW'(op_WEbit), RW'(0));
        check("rst_done",      RW'(op_writeDone), RW'(0));
        check("rst_busy",      RW'(op_busy), RW'(0));
        check("rst_err",       RW'(op_err), RW'(0));
        check("rst_rdAddr1",   RW'(op_rdAddr1), RW'(11'h7FF));
        check("rst_rdAddr2",   RW'(op_rdAddr2), RW'(11'h7FF));
        check("rst_wrAddr",    RW'(op_writeAddress), RW'(11'h7FF));
        check("rst_wrData",    op_writeData, '0);
        rst_n = 1'b1;
        step();
        check("ready_after_rst", RW'(in_ready), RW'(1));

        // Default pair: two rows, two writes, done one cycle after the last write
        w0 = n_wr; d0 = n_done; e0 = n_err;
        push_entry(mk(11'h010, 4'b0001, 48'hAAAA_AAAA_AAAA, 11'h020, 4'b0100, 48'h5555_5555_5555));
        wait_idle();
        check("def_writes", RW'(n_wr - w0), RW'(2));
        check("def_done",   RW'(n_done - d0), RW'(1));
        check("def_done_lat", RW'(done_cyc - last_wr_cyc), RW'(1));
        check("def_err",    RW'(n_err - e0), RW'(0));
        row = '1; row[0 +: DW] = 48'hAAAA_AAAA_AAAA;
        check("def_row010", mem[11'h010], row);
        row = '1; row[2*SLOT_W +: DW] = 48'h5555_5555_5555;
        check("def_row020", mem[11'h020], row);

        // Same row, different lanes: one merged write
        w0 = n_wr; e0 = n_err;
        push_entry(mk(11'h033, 4'b0010, 48'h1111_2222_3333, 11'h033, 4'b1000, 48'h4444_5555_6666));
        wait_idle();
        check("same_writes", RW'(n_wr - w0), RW'(1));
        check("same_err",    RW'(n_err - e0), RW'(0));
        row = '1; row[1*SLOT_W +: DW] = 48'h1111_2222_3333; row[3*SLOT_W +: DW] = 48'h4444_5555_6666;
        check("same_row033", mem[11'h033], row);

        // Same row, same lane: diagonal wins and op_err pulses
        w0 = n_wr; e0 = n_err;
        push_entry(mk(11'h044, 4'b0100, 48'h1234_5678_9ABC, 11'h044, 4'b0100, 48'hDEAD_BEEF_0000));
        wait_idle();
        check("conf_writes", RW'(n_wr - w0), RW'(1));
        check("conf_err",    RW'(n_err - e0), RW'(1));
        row = '1; row[2*SLOT_W +: DW] = 48'h1234_5678_9ABC;
        check("conf_row044", mem[11'h044], row);

        // Malformed one-hot: dropped, error, no writes, still a done pulse
        w0 = n_wr; d0 = n_done; e0 = n_err;
        push_entry(mk(11'h050, 4'b0110, 48'h0, 11'h051, 4'b0001, 48'h0));
        wait_idle();
        check("inv_writes", RW'(n_wr - w0), RW'(0));
        check("inv_err",    RW'(n_err - e0), RW'(1));
        check("inv_done",   RW'(n_done - d0), RW'(1));

        // Backpressure: 6 back-to-back pairs; head leaves the FIFO at once,
        // so in_ready drops once DEPTH more are queued behind it
        w0 = n_wr; d0 = n_done; stall_at = -1; acc_base = n_acc;
        for (int k = 0; k < 6; k++)
            push_entry(mk(AW'(11'h060 + 2*k), 4'b0001 << (k % 4), DW'($urandom),
                          AW'(11'h061 + 2*k), 4'b1000 >> (k % 4), DW'($urandom)));
        wait_idle();
        check("bp_stall_at", RW'(stall_at), RW'(DEPTH + 1));
        check("bp_writes",   RW'(n_wr - w0), RW'(12));
        check("bp_done",     RW'(n_done - d0), RW'(1));
        check("bp_done_lat", RW'(done_cyc - last_wr_cyc), RW'(1));

        // Hazard: consecutive updates to lanes 0 and 3 of row 0x100
        push_entry(mk(11'h100, 4'b0001, 48'h0123_4567_89AB, 11'h110, 4'b0010, 48'h0BAD_F00D_0001));
        push_entry(mk(11'h100, 4'b1000, 48'hFEDC_BA98_7654, 11'h120, 4'b0100, 48'h0BAD_F00D_0002));
        wait_idle();
        row = '1; row[0 +: DW] = 48'h0123_4567_89AB; row[3*SLOT_W +: DW] = 48'hFEDC_BA98_7654;
        check("hazard_row100", mem[11'h100], row);

        // Randomized pairs over a small row set (hazards, same-row, conflicts, bad one-hots)
        e0 = n_err; x0 = exp_err;
        for (int k = 0; k < 40; k++) begin
            e.da  = AW'(11'h200 + $urandom_range(0, 5));
            e.na  = AW'(11'h200 + $urandom_range(0, 5));
            e.doh = ($urandom_range(0, 7) == 0) ? LANES'($urandom) : LANES'(4'b0001 << $urandom_range(0, 3));
            e.noh = ($urandom_range(0, 7) == 0) ? LANES'($urandom) : LANES'(4'b0001 << $urandom_range(0, 3));
            e.dv  = {16'($urandom), 32'($urandom)};
            e.nv  = {16'($urandom), 32'($urandom)};
            push_entry(e);
            repeat ($urandom_range(0, 3)) step();
        end
        wait_idle();
        check("rnd_drained", RW'(exp_q.size()), RW'(0));
        check("rnd_err",     RW'(n_err - e0), RW'(exp_err - x0));

        // Asynchronous reset during WAIT discards the in-flight and queued pairs
        w0 = n_wr; d0 = n_done;
        push_entry(mk(11'h300, 4'b0001, 48'hC0DE_C0DE_C0DE, 11'h301, 4'b0010, 48'hBEEF_BEEF_BEEF));
        push_entry(mk(11'h302, 4'b0001, 48'h1, 11'h303, 4'b0010, 48'h2));
        begin
            int n;
            n = 0;
            while (!op_rdEn && n < 50) begin
                step();
                n++;
            end
            check("rst_fetch_seen", RW'(op_rdEn), RW'(1));
        end
        step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_WEbit",  RW'(op_WEbit), RW'(0));
        check("arst_done",   RW'(op_writeDone), RW'(0));
        check("arst_busy",   RW'(op_busy), RW'(0));
        check("arst_ready",  RW'(in_ready), RW'(0));
        check("arst_rdAddr1", RW'(op_rdAddr1), RW'(11'h7FF));
        check("arst_wrAddr", RW'(op_writeAddress), RW'(11'h7FF));
        exp_q.delete();
        ref_row.delete();
        mem_clear = 1'b1;
        step();
        mem_clear = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (12) step();
        check("arst_no_write", RW'(n_wr - w0), RW'(0));
        check("arst_no_done",  RW'(n_done - d0), RW'(0));
        check("arst_fifo_empty", RW'(op_busy), RW'(0));
        check("arst_ready_back", RW'(in_ready), RW'(1));

        // Engine still operational after reset
        w0 = n_wr;
        push_entry(mk(11'h310, 4'b0100, 48'h7777_8888_9999, 11'h311, 4'b0001, 48'h0101_0202_0303));
        wait_idle();
        check("post_rst_writes", RW'(n_wr - w0), RW'(2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
